// File: rtl/wb_shared_arbiter_pkg.sv
// rtl/wb_shared_arbiter_pkg.sv - shared types and constants for the Wishbone CPU/DMA arbiter
//
// Purpose: arbiter state encoding, grant bit positions and a grant-vector decode
//          helper shared by wb_shared_arbiter and wb_arb_pick.
// Ports:   none (package).
package wb_shared_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DMA = 2'd2
  } arb_state_e;

  localparam int GNT_CPU_BIT = 0;
  localparam int GNT_DMA_BIT = 1;

  // One-hot (or zero) grant vector for a given state; never 2'b11.
  function automatic logic [1:0] grant_of(input arb_state_e st);
    logic [1:0] g;
    g = 2'b00;
    if (st == GNT_CPU) g[GNT_CPU_BIT] = 1'b1;
    if (st == GNT_DMA) g[GNT_DMA_BIT] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/wb_shared_arbiter_pick.sv
// rtl/wb_shared_arbiter_pick.sv - combinational CPU/DMA tie-break for the shared arbiter
//
// Purpose: chooses which requesting master wins when the arbiter is idle.
//          A lone requester always wins. On a tie the master that was not
//          granted last wins; holding last_cpu at 0 gives fixed CPU priority.
// Ports:
//   cpu_req  in  1  CPU has cyc and stb high
//   dma_req  in  1  DMA has cyc and stb high
//   last_cpu in  1  CPU received the most recent grant
//   pick_cpu out 1  grant the CPU next
//   pick_dma out 1  grant the DMA next (never together with pick_cpu)
module wb_arb_pick
  import wb_shared_arbiter_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_cpu,
  output logic pick_cpu,
  output logic pick_dma
);

  assign pick_cpu = cpu_req && (!dma_req || !last_cpu);
  assign pick_dma = dma_req && (!cpu_req ||  last_cpu);

endmodule

// File: rtl/wb_shared_arbiter.sv
// rtl/wb_shared_arbiter.sv - two-master (CPU, DMA) to one-slave Wishbone arbiter
//
// Purpose: grants the shared slave to one master for exactly one transfer.
//          A request seen in IDLE is granted at the next edge; the granted
//          master's bus is mirrored combinationally to the slave; ack/read
//          data are routed only to the grant holder. An ack or a dropped cyc
//          ends the grant at the next edge.
// Configuration: define WB_ARB_ROUND_ROBIN_EN for round-robin tie-break
//          (last-grant register, reset value DMA); otherwise CPU has fixed
//          priority over DMA.
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   cpu_{cyc,stb,we,sel,adr,dat}_i  CPU master request side
//   cpu_ack_o, cpu_dat_o        CPU master response side
//   dma_{cyc,stb,we,sel,adr,dat}_i  DMA master request side
//   dma_ack_o, dma_dat_o        DMA master response side
//   s_{cyc,stb,we,sel,adr,dat}_o    shared slave request side
//   s_ack_i, s_dat_i            shared slave response side
//   grant_o                     registered grant: bit0 CPU, bit1 DMA
module wb_shared_arbiter
  import wb_shared_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,

  input  logic          cpu_cyc_i,
  input  logic          cpu_stb_i,
  input  logic          cpu_we_i,
  input  logic [3:0]    cpu_sel_i,
  input  logic [AW-1:0] cpu_adr_i,
  input  logic [DW-1:0] cpu_dat_i,
  output logic          cpu_ack_o,
  output logic [DW-1:0] cpu_dat_o,

  input  logic          dma_cyc_i,
  input  logic          dma_stb_i,
  input  logic          dma_we_i,
  input  logic [3:0]    dma_sel_i,
  input  logic [AW-1:0] dma_adr_i,
  input  logic [DW-1:0] dma_dat_i,
  output logic          dma_ack_o,
  output logic [DW-1:0] dma_dat_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic          s_ack_i,
  input  logic [DW-1:0] s_dat_i,

  output logic [1:0]    grant_o
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q;
  logic       cpu_req, dma_req;
  logic       pick_cpu, pick_dma;
  logic       last_cpu;

  assign cpu_req = cpu_cyc_i && cpu_stb_i;
  assign dma_req = dma_cyc_i && dma_stb_i;

  wb_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .last_cpu (last_cpu),
    .pick_cpu (pick_cpu),
    .pick_dma (pick_dma)
  );

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Remembers who won the last arbitration; reset as if DMA had, so the
  // first tie goes to the CPU.
  logic last_cpu_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      last_cpu_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (pick_cpu)      last_cpu_q <= 1'b1;
      else if (pick_dma) last_cpu_q <= 1'b0;
    end
  end
  assign last_cpu = last_cpu_q;
`else
  assign last_cpu = 1'b0;
`endif

  // A grant ends on ack or when its owner abandons the cycle; either way the
  // arbiter passes through IDLE, which is what makes one grant = one transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_cpu)      state_d = GNT_CPU;
        else if (pick_dma) state_d = GNT_DMA;
      end
      GNT_CPU: if (!cpu_cyc_i || s_ack_i) state_d = IDLE;
      GNT_DMA: if (!dma_cyc_i || s_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_of(state_d);
    end
  end

  assign grant_o = grant_q;

  // Slave-side mux; IDLE drives an all-zero bus.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state_q)
      GNT_CPU: begin
        s_cyc_o = cpu_cyc_i;
        s_stb_o = cpu_stb_i;
        s_we_o  = cpu_we_i;
        s_sel_o = cpu_sel_i;
        s_adr_o = cpu_adr_i;
        s_dat_o = cpu_dat_i;
      end
      GNT_DMA: begin
        s_cyc_o = dma_cyc_i;
        s_stb_o = dma_stb_i;
        s_we_o  = dma_we_i;
        s_sel_o = dma_sel_i;
        s_adr_o = dma_adr_i;
        s_dat_o = dma_dat_i;
      end
      default: ;
    endcase
  end

  // Ack is qualified by the owner's cyc so an ack landing in the abort cycle
  // is discarded just like a late one.
  assign cpu_ack_o = (state_q == GNT_CPU) && cpu_cyc_i && s_ack_i;
  assign dma_ack_o = (state_q == GNT_DMA) && dma_cyc_i && s_ack_i;
  assign cpu_dat_o = (state_q == GNT_CPU) ? s_dat_i : '0;
  assign dma_dat_o = (state_q == GNT_DMA) ? s_dat_i : '0;

endmodule

// File: tb/tb_wb_shared_arbiter.sv
// tb/tb_wb_shared_arbiter.sv - self-checking bench for wb_shared_arbiter
module tb_wb_shared_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [AW-1:0] CPU_ADR = 32'h3800_0100;
  localparam logic [DW-1:0] CPU_DAT = 32'h1234_5678;
  localparam logic [AW-1:0] DMA_ADR = 32'h3800_0200;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic [3:0]    cpu_sel_i;
  logic [AW-1:0] cpu_adr_i;
  logic [DW-1:0] cpu_dat_i;
  logic          cpu_ack_o;
  logic [DW-1:0] cpu_dat_o;
  logic          dma_cyc_i, dma_stb_i, dma_we_i;
  logic [3:0]    dma_sel_i;
  logic [AW-1:0] dma_adr_i;
  logic [DW-1:0] dma_dat_i;
  logic          dma_ack_o;
  logic [DW-1:0] dma_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]    s_sel_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic          s_ack_i;
  logic [DW-1:0] s_dat_i;
  logic [1:0]    grant_o;

  wb_shared_arbiter #(.AW(AW), .DW(DW)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_ack_o(cpu_ack_o), .cpu_dat_o(cpu_dat_o),
    .dma_cyc_i(dma_cyc_i), .dma_stb_i(dma_stb_i), .dma_we_i(dma_we_i),
    .dma_sel_i(dma_sel_i), .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i),
    .dma_ack_o(dma_ack_o), .dma_dat_o(dma_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       cc, cs, dc, ds, ack;   // stimulus for one cycle
    logic [1:0] g;                     // expected grant_o
    logic       scyc, cack, dack;      // expected s_cyc_o, cpu_ack_o, dma_ack_o
  } vec_t;

  vec_t tbl[18];

  task automatic drive(input logic cc, input logic cs, input logic dc, input logic ds, input logic ack);
    cpu_cyc_i = cc; cpu_stb_i = cs; cpu_we_i = 1'b1; cpu_sel_i = 4'hF;
    cpu_adr_i = CPU_ADR; cpu_dat_i = CPU_DAT;
    dma_cyc_i = dc; dma_stb_i = ds; dma_we_i = 1'b0; dma_sel_i = 4'h3;
    dma_adr_i = DMA_ADR; dma_dat_i = 32'hDEAD_0000;
    s_ack_i = ack; s_dat_i = $urandom;
  endtask

  // Checks the routing that follows from a known grant vector.
  task automatic chk_route(input string tag, input logic [1:0] g);
    if (g == 2'b01) begin
      chk({tag, " s_adr"}, 64'(s_adr_o), 64'(cpu_adr_i));
      chk({tag, " s_dat"}, 64'(s_dat_o), 64'(cpu_dat_i));
      chk({tag, " s_sel"}, 64'(s_sel_o), 64'(cpu_sel_i));
      chk({tag, " s_we"}, 64'(s_we_o), 64'(cpu_we_i));
    end else if (g == 2'b10) begin
      chk({tag, " s_adr"}, 64'(s_adr_o), 64'(dma_adr_i));
      chk({tag, " s_dat"}, 64'(s_dat_o), 64'(dma_dat_i));
      chk({tag, " s_sel"}, 64'(s_sel_o), 64'(dma_sel_i));
      chk({tag, " s_we"}, 64'(s_we_o), 64'(dma_we_i));
    end else begin
      chk({tag, " s_stb"}, 64'(s_stb_o), 64'd0);
      chk({tag, " s_sel"}, 64'(s_sel_o), 64'd0);
    end
    chk({tag, " cpu_dat"}, 64'(cpu_dat_o), (g == 2'b01) ? 64'(s_dat_i) : 64'd0);
    chk({tag, " dma_dat"}, 64'(dma_dat_o), (g == 2'b10) ? 64'(s_dat_i) : 64'd0);
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  // Reference model: who owns the bus, and who won the last arbitration.
  int   own;       // 0 nobody, 1 CPU, 2 DMA
  logic m_last_cpu;

  initial begin
    // cc cs dc ds ack | grant scyc cack dack
    tbl[0]  = '{0,0,0,0,0, 2'b00, 0,0,0};  // idle
    tbl[1]  = '{1,1,0,0,0, 2'b00, 0,0,0};  // CPU request seen in IDLE
    tbl[2]  = '{1,1,0,0,1, 2'b01, 1,1,0};  // granted one cycle later, acked
    tbl[3]  = '{0,0,0,0,0, 2'b00, 0,0,0};
    tbl[4]  = '{0,0,0,0,1, 2'b00, 0,0,0};  // stray ack in IDLE
    tbl[5]  = '{0,0,1,1,0, 2'b00, 0,0,0};  // DMA request
    tbl[6]  = '{0,0,1,1,0, 2'b10, 1,0,0};  // DMA granted, no ack yet
    tbl[7]  = '{0,0,0,0,0, 2'b10, 0,0,0};  // DMA aborts: s_cyc drops same cycle
    tbl[8]  = '{0,0,0,0,1, 2'b00, 0,0,0};  // late ack discarded
    tbl[9]  = '{1,1,1,1,0, 2'b00, 0,0,0};  // tie (last winner: DMA)
    tbl[10] = '{1,1,1,1,1, 2'b01, 1,1,0};
    tbl[11] = '{1,1,1,1,0, 2'b00, 0,0,0};  // tie (last winner: CPU)
    tbl[12] = '{1,1,1,1,1, RR ? 2'b10 : 2'b01, 1, !RR, RR};
    tbl[13] = '{1,1,1,1,0, 2'b00, 0,0,0};
    tbl[14] = '{1,1,1,1,1, 2'b01, 1,1,0};
    tbl[15] = '{0,0,1,1,0, 2'b00, 0,0,0};  // CPU drops; DMA waiting
    tbl[16] = '{0,0,1,1,1, 2'b10, 1,0,1};  // DMA granted on next edge
    tbl[17] = '{0,0,0,0,0, 2'b00, 0,0,0};

    // Outputs while reset is held.
    wb_rst_i = 1'b1;
    drive(1, 1, 1, 1, 1);
    #1;
    chk("rst grant", 64'(grant_o), 64'd0);
    chk("rst s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst s_stb", 64'(s_stb_o), 64'd0);
    chk("rst cpu_ack", 64'(cpu_ack_o), 64'd0);
    chk("rst dma_ack", 64'(dma_ack_o), 64'd0);
    do_reset();

    // Directed table.
    for (int i = 0; i < 18; i++) begin
      @(posedge wb_clk_i); #1;
      drive(tbl[i].cc, tbl[i].cs, tbl[i].dc, tbl[i].ds, tbl[i].ack);
      #1;
      chk($sformatf("row%0d grant", i), 64'(grant_o), 64'(tbl[i].g));
      chk($sformatf("row%0d s_cyc", i), 64'(s_cyc_o), 64'(tbl[i].scyc));
      chk($sformatf("row%0d cpu_ack", i), 64'(cpu_ack_o), 64'(tbl[i].cack));
      chk($sformatf("row%0d dma_ack", i), 64'(dma_ack_o), 64'(tbl[i].dack));
      chk_route($sformatf("row%0d", i), tbl[i].g);
    end

    // Reset asserted mid-transfer.
    @(posedge wb_clk_i); #1;
    drive(1, 1, 0, 0, 0);
    @(posedge wb_clk_i); #1;
    chk("mid grant before rst", 64'(grant_o), 64'b01);
    chk("mid s_stb before rst", 64'(s_stb_o), 64'd1);
    wb_rst_i = 1'b1;
    s_ack_i = 1'b1;
    #1;
    chk("mid rst grant", 64'(grant_o), 64'd0);
    chk("mid rst s_cyc", 64'(s_cyc_o), 64'd0);
    chk("mid rst s_stb", 64'(s_stb_o), 64'd0);
    chk("mid rst cpu_ack", 64'(cpu_ack_o), 64'd0);
    chk("mid rst cpu_dat", 64'(cpu_dat_o), 64'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    s_ack_i = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("post rst grant", 64'(grant_o), 64'b01);
    chk("post rst s_adr", 64'(s_adr_o), 64'(CPU_ADR));
    s_ack_i = 1'b1;
    #1;
    chk("post rst cpu_ack", 64'(cpu_ack_o), 64'd1);

    // Randomized traffic against the reference model.
    do_reset();
    own = 0;
    m_last_cpu = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic creq, dreq;
      logic [1:0] eg;
      @(posedge wb_clk_i); #1;
      cpu_cyc_i = ($urandom_range(0, 3) != 0);
      cpu_stb_i = cpu_cyc_i && ($urandom_range(0, 4) != 0);
      cpu_we_i  = $urandom_range(0, 1);
      cpu_sel_i = 4'($urandom);
      cpu_adr_i = $urandom;
      cpu_dat_i = $urandom;
      dma_cyc_i = ($urandom_range(0, 3) != 0);
      dma_stb_i = dma_cyc_i && ($urandom_range(0, 4) != 0);
      dma_we_i  = $urandom_range(0, 1);
      dma_sel_i = 4'($urandom);
      dma_adr_i = $urandom;
      dma_dat_i = $urandom;
      s_ack_i   = ($urandom_range(0, 2) == 0);
      s_dat_i   = $urandom;
      #1;
      eg = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
      chk("rnd grant", 64'(grant_o), 64'(eg));
      chk("rnd s_cyc", 64'(s_cyc_o), (own == 1) ? 64'(cpu_cyc_i) : (own == 2) ? 64'(dma_cyc_i) : 64'd0);
      chk("rnd s_stb", 64'(s_stb_o), (own == 1) ? 64'(cpu_stb_i) : (own == 2) ? 64'(dma_stb_i) : 64'd0);
      chk("rnd cpu_ack", 64'(cpu_ack_o), 64'(own == 1 && cpu_cyc_i && s_ack_i));
      chk("rnd dma_ack", 64'(dma_ack_o), 64'(own == 2 && dma_cyc_i && s_ack_i));
      chk_route("rnd", eg);

      // Ownership for the next cycle.
      creq = cpu_cyc_i && cpu_stb_i;
      dreq = dma_cyc_i && dma_stb_i;
      if (own == 0) begin
        if (creq && dreq) own = (RR && m_last_cpu) ? 2 : 1;
        else if (creq)    own = 1;
        else if (dreq)    own = 2;
        if (own != 0) m_last_cpu = (own == 1);
      end else if (own == 1) begin
        if (!cpu_cyc_i || s_ack_i) own = 0;
      end else begin
        if (!dma_cyc_i || s_ack_i) own = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
